// File: rtl/rs_issue_scheduler_pkg.sv
// rs_pkg: shared widths, entry record and the reserved "no entry" age
package rs_pkg;
  localparam int TAG_WIDTH = 6;
  localparam int PAYLOAD_WIDTH = 64;
  localparam int AGE_MAX_WIDTH = 16;
  localparam logic [AGE_MAX_WIDTH-1:0] AGE_NONE = '1;
  typedef struct packed {
    logic valid;
    logic [1:0] src_rdy;
    logic [1:0][TAG_WIDTH-1:0] src_tag;
    logic [AGE_MAX_WIDTH-1:0] age;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } rs_entry_t;
endpackage

// File: rtl/rs_issue_scheduler_oldest2_select.sv
// rs_oldest2_select: picks the oldest and second-oldest ready entries
module rs_oldest2_select
  import rs_pkg::*;
#(
  parameter int RS_SIZE = 4,
  parameter int RS_INDEX_WIDTH = 2
) (
  input  logic [RS_SIZE-1:0] ready,
  input  logic [AGE_MAX_WIDTH-1:0] age [RS_SIZE],
  output logic first_valid,
  output logic [RS_INDEX_WIDTH-1:0] first_index,
  output logic second_valid,
  output logic [RS_INDEX_WIDTH-1:0] second_index
);
  logic [AGE_MAX_WIDTH-1:0] best0, best1;
  // two min-scans; stored ages never reach AGE_NONE so it serves as "nothing found"
  always_comb begin
    first_valid = 1'b0;
    first_index = '0;
    second_valid = 1'b0;
    second_index = '0;
    best0 = AGE_NONE;
    best1 = AGE_NONE;
    for (int i = 0; i < RS_SIZE; i++)
      if (ready[i] && age[i] < best0) begin
        best0 = age[i];
        first_valid = 1'b1;
        first_index = RS_INDEX_WIDTH'(i);
      end
    for (int i = 0; i < RS_SIZE; i++)
      if (ready[i] && first_index != RS_INDEX_WIDTH'(i) && age[i] < best1) begin
        best1 = age[i];
        second_valid = 1'b1;
        second_index = RS_INDEX_WIDTH'(i);
      end
  end
endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: reservation station with wakeup CAM and two-port oldest-first issue
module rs_issue_scheduler
  import rs_pkg::*;
#(
  parameter int RS_SIZE = 4,
  parameter int RS_INDEX_WIDTH = 2,
  parameter int AGE_WIDTH = 16,
  parameter int WB_PORTS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic alloc_valid_i,
  output logic alloc_ready_o,
  input  logic [2*TAG_WIDTH-1:0] alloc_src_tag_i,
  input  logic [1:0] alloc_src_rdy_i,
  input  logic [PAYLOAD_WIDTH-1:0] alloc_payload_i,
  input  logic [WB_PORTS-1:0] wb_valid_i,
  input  logic [WB_PORTS*TAG_WIDTH-1:0] wb_tag_i,
  output logic [1:0] issue_valid_o,
  input  logic [1:0] issue_ready_i,
  output logic [2*PAYLOAD_WIDTH-1:0] issue_payload_o,
  output logic [2*RS_INDEX_WIDTH-1:0] issue_index_o,
  output logic [RS_INDEX_WIDTH:0] occupancy_o
);
  localparam logic [AGE_WIDTH-1:0] AGE_LAST = '1;
  rs_entry_t ent [RS_SIZE];
  logic [AGE_WIDTH-1:0] age_cnt;
  logic [RS_SIZE-1:0] rdy_vec, freed, remain;
  logic [AGE_MAX_WIDTH-1:0] ages [RS_SIZE];
  logic [1:0] wake [RS_SIZE];
  logic [1:0] alloc_wake;
  logic v0, v1, free_any, fire;
  logic [RS_INDEX_WIDTH-1:0] i0, i1, free_idx;

  function automatic logic hit(input logic [TAG_WIDTH-1:0] t, input logic [WB_PORTS-1:0] v,
                               input logic [WB_PORTS*TAG_WIDTH-1:0] tags);
    hit = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) hit |= v[p] && tags[p*TAG_WIDTH +: TAG_WIDTH] == t;
  endfunction

  // per-entry readiness, ages, tag-match CAM, lowest free slot and occupancy
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    occupancy_o = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      rdy_vec[i] = ent[i].valid && &ent[i].src_rdy;
      ages[i] = ent[i].age;
      for (int k = 0; k < 2; k++) wake[i][k] = hit(ent[i].src_tag[k], wb_valid_i, wb_tag_i);
      occupancy_o += (RS_INDEX_WIDTH+1)'(ent[i].valid);
    end
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!ent[i].valid) begin
        free_any = 1'b1;
        free_idx = RS_INDEX_WIDTH'(i);
      end
    for (int k = 0; k < 2; k++)
      alloc_wake[k] = hit(alloc_src_tag_i[k*TAG_WIDTH +: TAG_WIDTH], wb_valid_i, wb_tag_i);
  end

  rs_oldest2_select #(.RS_SIZE(RS_SIZE), .RS_INDEX_WIDTH(RS_INDEX_WIDTH)) u_sel (
    .ready(rdy_vec), .age(ages),
    .first_valid(v0), .first_index(i0), .second_valid(v1), .second_index(i1)
  );

  assign issue_valid_o = {v1, v0};
  assign issue_payload_o = {ent[i1].payload, ent[i0].payload};
  assign issue_index_o = {i1, i0};
  assign alloc_ready_o = !flush_i && free_any && age_cnt != AGE_LAST;
  assign fire = alloc_valid_i && alloc_ready_o;

  // entries leaving through an accepted issue port, and what survives the edge
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      freed[i] = (v0 && issue_ready_i[0] && i0 == RS_INDEX_WIDTH'(i)) ||
                 (v1 && issue_ready_i[1] && i1 == RS_INDEX_WIDTH'(i));
      remain[i] = ent[i].valid && !freed[i];
    end
  end

  // entry array and age counter; free slot chosen from pre-edge state so a freed slot is not reused at once
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      age_cnt <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++)
        if (freed[i]) ent[i].valid <= 1'b0;
        else if (ent[i].valid) ent[i].src_rdy <= ent[i].src_rdy | wake[i];
      if (fire) begin
        ent[free_idx].valid <= 1'b1;
        ent[free_idx].src_rdy <= alloc_src_rdy_i | alloc_wake;
        ent[free_idx].src_tag <= alloc_src_tag_i;
        ent[free_idx].age <= AGE_MAX_WIDTH'(age_cnt);
        ent[free_idx].payload <= alloc_payload_i;
      end
      age_cnt <= fire ? age_cnt + 1'b1 : (|remain ? age_cnt : '0);
    end
  end
endmodule
